// File: rtl/rom_load_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rom_load_ctrl_pkg
// Purpose  : Shared types and constants for the ROM load controller: the
//            controller state encoding, the iNES magic word, header length
//            and the PRG/CHR/trainer unit sizes used for body length.
// Revision : 1.0 - initial release
// ============================================================================
package rom_load_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_BODY   = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  // Body length is carried as a 22-bit unsigned quantity.
  typedef logic [21:0] body_len_t;

  // "NES<EOF>" with byte 0 in the least significant lane.
  localparam logic [31:0] c_ines_magic   = 32'h1A53_454E;
  localparam logic [3:0]  c_hdr_last_idx = 4'd15;

  localparam body_len_t c_prg_unit     = 22'd16384;
  localparam body_len_t c_chr_unit     = 22'd8192;
  localparam body_len_t c_trainer_unit = 22'd512;

  // Expected magic byte for header positions 0..3.
  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    return c_ines_magic[{idx, 3'b000} +: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/rom_load_ctrl_ines_header_parse.sv
`default_nettype none
// ============================================================================
// Module   : ines_header_parse
// Purpose  : Watches the 16 iNES header bytes as they are accepted, checks
//            the magic bytes and captures the PRG/CHR unit counts and the
//            trainer flag, from which the body length is derived.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            clear           - drop captured fields (controller idle)
//            byte_valid      - a header byte is accepted this cycle
//            byte_index      - position of that byte within the header
//            byte_data       - the byte itself
//            magic_ok        - current byte matches the magic (1 past idx 3)
//            body_len        - PRG*16384 + CHR*8192 + trainer*512 (22 bits)
//            prg_zero        - captured PRG unit count is zero
// Revision : 1.0 - initial release
// ============================================================================
module ines_header_parse
  import rom_load_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       byte_valid,
  input  logic [3:0] byte_index,
  input  logic [7:0] byte_data,
  output logic       magic_ok,
  output body_len_t  body_len,
  output logic       prg_zero
);

  logic [7:0] r_prg;
  logic [7:0] r_chr;
  logic       r_trainer;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_prg     <= 8'd0;
      r_chr     <= 8'd0;
      r_trainer <= 1'b0;
    end else if (byte_valid) begin
      case (byte_index)
        4'd4:    r_prg     <= byte_data;
        4'd5:    r_chr     <= byte_data;
        4'd6:    r_trainer <= byte_data[2];
        default: ;
      endcase
    end
  end

  // Combinational so the controller can reject the offending byte in the
  // same cycle it is accepted.
  assign magic_ok = (byte_index > 4'd3) || (byte_data == magic_byte(byte_index[1:0]));

  // Fields are captured from bytes 4..6, so they are stable by the time the
  // last header byte arrives; the sum wraps at 22 bits.
  assign body_len = body_len_t'(r_prg) * c_prg_unit
                  + body_len_t'(r_chr) * c_chr_unit
                  + body_len_t'(r_trainer) * c_trainer_unit;

  assign prg_zero = (r_prg == 8'd0);

endmodule
`default_nettype wire

// File: rtl/rom_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rom_load_ctrl
// Purpose  : Arbitrates between two byte sources (embedded ROM pump, external
//            stream), validates an iNES header and forwards header + body
//            bytes to a loader as odata/odata_clk strobes with a minimum gap.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            req[1:0]            - per-source load request (bit1 wins)
//            s_data0/1, s_valid0/1, s_ready0/1 - source byte handshakes
//            grant[1:0]          - one-hot owner, 00 when idle
//            odata, odata_clk    - forwarded byte and its one-cycle strobe
//            loader_reset        - high while idle
//            done, error         - load finished / aborted (levels)
// Revision : 1.0 - initial release
// ============================================================================
module rom_load_ctrl
  import rom_load_ctrl_pkg::*;
#(
  parameter int unsigned GAP     = 1,
  parameter int unsigned TIMEOUT = 1048575
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [7:0] s_data0,
  input  logic [7:0] s_data1,
  input  logic       s_valid0,
  input  logic       s_valid1,
  output logic       s_ready0,
  output logic       s_ready1,
  output logic [1:0] grant,
  output logic [7:0] odata,
  output logic       odata_clk,
  output logic       loader_reset,
  output logic       done,
  output logic       error
);

  localparam int unsigned c_gap_w = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int unsigned c_to_w  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_gap_w-1:0] c_gap_load = c_gap_w'(GAP);
  localparam logic [c_to_w-1:0]  c_to_limit = c_to_w'(TIMEOUT);

  state_t             r_state;
  state_t             w_state_next;
  logic [1:0]         r_grant;
  logic [1:0]         w_grant_next;
  logic [c_gap_w-1:0] r_gap;
  logic [c_to_w-1:0]  r_to_cnt;
  logic [3:0]         r_hdr_idx;
  body_len_t          r_remain;
  logic [7:0]         r_odata;
  logic               r_odata_clk;

  logic       w_req_held;
  logic       w_xfer_phase;
  logic       w_timeout;
  logic       w_open;
  logic       w_take;
  logic [7:0] w_byte;
  logic       w_magic_ok;
  body_len_t  w_body_len;
  logic       w_prg_zero;

  // The owner's request must still be up; dropping it blocks any further
  // transfer immediately, the ERROR transition follows on the next edge.
  assign w_req_held   = |(req & r_grant);
  assign w_xfer_phase = (r_state == ST_HEADER) || (r_state == ST_BODY);
  assign w_timeout    = (r_to_cnt == c_to_limit);
  assign w_open       = w_xfer_phase && w_req_held && (r_gap == '0) && !w_timeout;

  assign s_ready0 = w_open && r_grant[0];
  assign s_ready1 = w_open && r_grant[1];

  assign w_take = (s_valid0 && s_ready0) || (s_valid1 && s_ready1);
  assign w_byte = r_grant[1] ? s_data1 : s_data0;

  ines_header_parse u_hdr (
    .clk        (clk),
    .reset      (reset),
    .clear      (r_state == ST_IDLE),
    .byte_valid (w_take && (r_state == ST_HEADER)),
    .byte_index (r_hdr_idx),
    .byte_data  (w_byte),
    .magic_ok   (w_magic_ok),
    .body_len   (w_body_len),
    .prg_zero   (w_prg_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_grant <= 2'b00;
    end else begin
      r_state <= w_state_next;
      r_grant <= w_grant_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    case (r_state)
      ST_IDLE: begin
        if (req[1]) begin
          w_grant_next = 2'b10;
          w_state_next = ST_HEADER;
        end else if (req[0]) begin
          w_grant_next = 2'b01;
          w_state_next = ST_HEADER;
        end
      end
      ST_HEADER: begin
        if (!w_req_held || w_timeout) begin
          w_state_next = ST_ERROR;
        end else if (w_take) begin
          if (!w_magic_ok) begin
            w_state_next = ST_ERROR;
          end else if (r_hdr_idx == c_hdr_last_idx) begin
            if (w_prg_zero)              w_state_next = ST_ERROR;
            else if (w_body_len == '0)   w_state_next = ST_DONE;  // 22-bit wrap
            else                         w_state_next = ST_BODY;
          end
        end
      end
      ST_BODY: begin
        if (!w_req_held || w_timeout) begin
          w_state_next = ST_ERROR;
        end else if (w_take && (r_remain == body_len_t'(1))) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (!w_req_held) begin
          w_state_next = ST_IDLE;
          w_grant_next = 2'b00;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_grant_next = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gap       <= '0;
      r_to_cnt    <= '0;
      r_hdr_idx   <= 4'd0;
      r_remain    <= '0;
      r_odata     <= 8'd0;
      r_odata_clk <= 1'b0;
    end else begin
      r_odata_clk <= w_take;
      if (w_take) begin
        r_odata <= w_byte;
      end
      if (r_state == ST_IDLE) begin
        r_gap     <= '0;
        r_to_cnt  <= '0;
        r_hdr_idx <= 4'd0;
        r_remain  <= '0;
      end else if (w_xfer_phase) begin
        if (w_take) begin
          r_gap    <= c_gap_load;
          r_to_cnt <= '0;
        end else begin
          if (r_gap != '0) r_gap <= r_gap - c_gap_w'(1);
          // Gap cycles count as stall time too.
          if (!w_timeout)  r_to_cnt <= r_to_cnt + c_to_w'(1);
        end
        if (w_take && (r_state == ST_HEADER)) begin
          r_hdr_idx <= r_hdr_idx + 4'd1;
          if (r_hdr_idx == c_hdr_last_idx) r_remain <= w_body_len;
        end
        if (w_take && (r_state == ST_BODY)) begin
          r_remain <= r_remain - body_len_t'(1);
        end
      end
    end
  end

  assign grant        = r_grant;
  assign odata        = r_odata;
  assign odata_clk    = r_odata_clk;
  assign loader_reset = (r_state == ST_IDLE);
  assign done         = (r_state == ST_DONE);
  assign error        = (r_state == ST_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_rom_load_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rom_load_ctrl
// Purpose  : Scoreboard bench for rom_load_ctrl. The driver pushes every byte
//            it hands over into a queue; monitors pop and compare on each
//            odata_clk strobe. A second instance with GAP=0 runs the long
//            trainer load back-to-back.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_load_ctrl;

  localparam int unsigned TB_GAP     = 1;
  localparam int unsigned TB_TIMEOUT = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [1:0] req;
  logic [7:0] s_data0, s_data1;
  logic       s_valid0, s_valid1;
  logic       s_ready0, s_ready1;
  logic [1:0] grant;
  logic [7:0] odata;
  logic       odata_clk, loader_reset, done, error;

  rom_load_ctrl #(.GAP(TB_GAP), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req),
    .s_data0(s_data0), .s_data1(s_data1),
    .s_valid0(s_valid0), .s_valid1(s_valid1),
    .s_ready0(s_ready0), .s_ready1(s_ready1),
    .grant(grant), .odata(odata), .odata_clk(odata_clk),
    .loader_reset(loader_reset), .done(done), .error(error)
  );

  logic [1:0] t_req;
  logic [7:0] t_data0, t_data1;
  logic       t_valid0, t_valid1;
  logic       t_ready0, t_ready1;
  logic [1:0] t_grant;
  logic [7:0] t_odata;
  logic       t_odata_clk, t_loader_reset, t_done, t_error;

  rom_load_ctrl #(.GAP(0), .TIMEOUT(TB_TIMEOUT)) dut_t (
    .clk(clk), .reset(reset), .req(t_req),
    .s_data0(t_data0), .s_data1(t_data1),
    .s_valid0(t_valid0), .s_valid1(t_valid1),
    .s_ready0(t_ready0), .s_ready1(t_ready1),
    .grant(t_grant), .odata(t_odata), .odata_clk(t_odata_clk),
    .loader_reset(t_loader_reset), .done(t_done), .error(t_error)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  logic [7:0] hdr [16];

  task automatic set_header(input logic [7:0] b2, input logic [7:0] prg,
                            input logic [7:0] chr, input logic [7:0] f6);
    for (int k = 0; k < 16; k++) hdr[k] = 8'h00;
    hdr[0] = 8'h4E; hdr[1] = 8'h45; hdr[2] = b2; hdr[3] = 8'h1A;
    hdr[4] = prg;   hdr[5] = chr;   hdr[6] = f6;
  endtask

  function automatic logic [7:0] stream_byte(input int i);
    logic [31:0] u;
    u = i;
    if (i < 16) return hdr[u[3:0]];
    return 8'(i * 7 + 3);
  endfunction

  // ---------------- monitors ----------------
  logic [7:0] exp_q [$];
  logic [7:0] exp_t [$];
  logic [7:0] mon_e, mon_te;
  int  cyc = 0;
  int  pulses = 0, pulses_t = 0;
  int  last_pulse = 0;
  bit  have_last = 1'b0;
  bit  check_gap = 1'b0;
  int  own_viol = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if ((s_ready0 && !grant[0]) || (s_ready1 && !grant[1])) own_viol++;
    if (!check_gap) have_last = 1'b0;
    if (odata_clk) begin
      pulses++;
      if (exp_q.size() == 0) begin
        check("unexpected odata_clk", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("odata", {24'd0, odata}, {24'd0, mon_e});
      end
      if (check_gap && have_last) check("pulse spacing", cyc - last_pulse, TB_GAP + 1);
      last_pulse = cyc;
      have_last  = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (t_odata_clk) begin
      pulses_t++;
      if (exp_t.size() == 0) begin
        check("unexpected t_odata_clk", 32'd1, 32'd0);
      end else begin
        mon_te = exp_t.pop_front();
        check("t_odata", {24'd0, t_odata}, {24'd0, mon_te});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic feed(input int src, input int limit, input bit stop_at_limit,
                      input int max_cyc, output int accepted, output int idle_after);
    int  i = 0;
    int  c = 0;
    int  since = 0;
    bit  rdy;
    forever begin
      @(negedge clk);
      if (done || error) break;
      if (stop_at_limit && i >= limit) break;
      if (c >= max_cyc) begin
        check("feed cycle budget expired", 32'd1, 32'd0);
        break;
      end
      if (src == 1) begin
        s_valid1 = (i < limit); s_data1 = stream_byte(i);
      end else begin
        s_valid0 = (i < limit); s_data0 = stream_byte(i);
      end
      #1;
      rdy = (src == 1) ? s_ready1 : s_ready0;
      if (rdy && i < limit) begin
        exp_q.push_back(stream_byte(i));
        i++;
        since = 0;
      end else begin
        since++;
      end
      c++;
    end
    if (src == 1) s_valid1 = 1'b0; else s_valid0 = 1'b0;
    accepted   = i;
    idle_after = since;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int acc, idle, p0, k;

  initial begin
    reset = 1'b1; req = 2'b00;
    s_data0 = 8'h00; s_data1 = 8'h00; s_valid0 = 1'b0; s_valid1 = 1'b0;
    t_req = 2'b00; t_data0 = 8'h00; t_data1 = 8'h00; t_valid0 = 1'b0; t_valid1 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst grant", grant, 2'b00);
    check("rst odata", odata, 8'h00);
    check("rst odata_clk", odata_clk, 1'b0);
    check("rst s_ready0", s_ready0, 1'b0);
    check("rst s_ready1", s_ready1, 1'b0);
    check("rst done", done, 1'b0);
    check("rst error", error, 1'b0);
    check("rst loader_reset", loader_reset, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check("idle loader_reset", loader_reset, 1'b1);

    // Full load from source 0: 1 PRG + 1 CHR = 24576 body bytes, GAP spacing
    set_header(8'h53, 8'd1, 8'd1, 8'h00);
    p0 = pulses; check_gap = 1'b1; req = 2'b01;
    feed(0, 16 + 24576, 1'b0, 50000, acc, idle);
    @(negedge clk);
    check_gap = 1'b0;
    check("t1 accepted", acc, 24592);
    check("t1 pulses", pulses - p0, 24592);
    check("t1 done", done, 1'b1);
    check("t1 error", error, 1'b0);
    check("t1 grant", grant, 2'b01);
    check("t1 loader_reset", loader_reset, 1'b0);
    check("t1 ready in done", s_ready0, 1'b0);
    req = 2'b00;
    @(negedge clk);
    check("t1 done cleared", done, 1'b0);
    check("t1 grant idle", grant, 2'b00);
    check("t1 loader_reset idle", loader_reset, 1'b1);

    // Both requests: source 1 wins; dropping req mid-body aborts
    set_header(8'h53, 8'd1, 8'd0, 8'h00);
    p0 = pulses; req = 2'b11; s_valid0 = 1'b1; s_data0 = 8'hA5;
    feed(1, 20, 1'b1, 200, acc, idle);
    check("t3 grant", grant, 2'b10);
    check("t3 no error yet", error, 1'b0);
    req = 2'b00; s_valid0 = 1'b0;
    @(negedge clk);
    check("t3 error on req drop", error, 1'b1);
    check("t3 grant held", grant, 2'b10);
    check("t3 ready1 low", s_ready1, 1'b0);
    @(negedge clk);
    check("t3 back idle", grant, 2'b00);
    check("t3 error cleared", error, 1'b0);
    check("t3 pulses", pulses - p0, 20);

    // Bad magic at byte 2
    set_header(8'h54, 8'd1, 8'd0, 8'h00);
    p0 = pulses; req = 2'b01;
    feed(0, 16, 1'b0, 200, acc, idle);
    @(negedge clk);
    check("t4 error", error, 1'b1);
    check("t4 accepted", acc, 3);
    check("t4 pulses", pulses - p0, 3);
    req = 2'b00;
    @(negedge clk);
    check("t4 error cleared", error, 1'b0);
    check("t4 loader_reset", loader_reset, 1'b1);

    // Stall mid-body until timeout
    set_header(8'h53, 8'd1, 8'd0, 8'h00);
    req = 2'b01;
    feed(0, 16 + 50, 1'b0, 400, acc, idle);
    check("t5 error", error, 1'b1);
    check("t5 accepted", acc, 66);
    check("t5 stall cycles", idle, TB_TIMEOUT + 1);
    req = 2'b00;
    @(negedge clk);
    check("t5 loader_reset", loader_reset, 1'b1);
    check("t5 grant idle", grant, 2'b00);
    check("t5 error cleared", error, 1'b0);

    // Reset mid-body with a transfer offered, then restart
    req = 2'b01;
    feed(0, 46, 1'b1, 200, acc, idle);
    k = 0;
    while (!s_ready0 && k < 4) begin @(negedge clk); k++; end
    check("t6 ready before reset", s_ready0, 1'b1);
    s_valid0 = 1'b1; s_data0 = 8'hEE; reset = 1'b1;
    @(negedge clk);
    check("t6 grant", grant, 2'b00);
    check("t6 odata", odata, 8'h00);
    check("t6 odata_clk", odata_clk, 1'b0);
    check("t6 s_ready0", s_ready0, 1'b0);
    check("t6 done", done, 1'b0);
    check("t6 error", error, 1'b0);
    check("t6 loader_reset", loader_reset, 1'b1);
    reset = 1'b0; s_valid0 = 1'b0;
    p0 = pulses;
    feed(0, 16, 1'b1, 100, acc, idle);
    @(negedge clk);
    check("t6 restart pulses", pulses - p0, 16);
    check("t6 restart grant", grant, 2'b01);
    check("t6 restart error", error, 1'b0);
    check("t6 restart loader_reset", loader_reset, 1'b0);
    req = 2'b00;
    @(negedge clk);
    check("t6 abort error", error, 1'b1);
    @(negedge clk);
    check("t6 idle", loader_reset, 1'b1);

    // Trainer load on the GAP=0 instance: 16384 + 512 body bytes
    set_header(8'h53, 8'd1, 8'd0, 8'h04);
    t_req = 2'b01; acc = 0; k = 0;
    forever begin
      @(negedge clk);
      if (t_done || t_error) break;
      if (k >= 20000) begin
        check("trainer cycle budget expired", 32'd1, 32'd0);
        break;
      end
      t_valid0 = 1'b1; t_data0 = stream_byte(acc);
      #1;
      if (t_ready0) begin
        exp_t.push_back(stream_byte(acc));
        acc++;
      end
      k++;
    end
    t_valid0 = 1'b0;
    @(negedge clk);
    check("t7 done", t_done, 1'b1);
    check("t7 error", t_error, 1'b0);
    check("t7 accepted", acc, 16 + 16384 + 512);
    check("t7 pulses", pulses_t, 16 + 16384 + 512);
    t_req = 2'b00;
    @(negedge clk);
    check("t7 loader_reset", t_loader_reset, 1'b1);
    check("t7 done cleared", t_done, 1'b0);

    check("non-owner ready seen", own_viol, 0);
    check("scoreboard drained", exp_q.size() + exp_t.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rom_load_ctrl.md
ROM_LOAD_CTRL -- requirements
Module: rom_load_ctrl

Interface
REQ-001 Parameter GAP, default 1: minimum idle cycles between consecutive odata_clk pulses (0 = back-to-back).
REQ-002 Parameter TIMEOUT, default 1048575: stall cycles without a source byte before a load is aborted.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 req  in  2  per-source load request; bit0 = embedded ROM pump, bit1 = external stream (UART/SD).
REQ-006 s_data0 / s_data1  in  8  source byte.
REQ-007 s_valid0 / s_valid1  in  1  source byte valid.
REQ-008 s_ready0 / s_ready1  out  1  controller accepts byte this cycle.
REQ-009 grant  out  2  one-hot current owner; 00 when idle.
REQ-010 odata  out  8  byte to loader.
REQ-011 odata_clk  out  1  one-cycle strobe marking a new odata.
REQ-012 loader_reset  out  1  held high while idle, low during a load.
REQ-013 done  out  1  load completed; level, cleared on return to IDLE.
REQ-014 error  out  1  load aborted (bad header or timeout); level, cleared on return to IDLE.

Function
REQ-015 FSM states: IDLE, HEADER, BODY, DONE, ERROR.
REQ-016 IDLE: any req bit set -> grant that source (bit1 wins when both set), clear counters, go HEADER next cycle.
REQ-017 Transfer rule: byte taken when s_validN && s_readyN; s_readyN = grant[N] && state in {HEADER, BODY} && gap counter == 0.
REQ-018 Accepted byte appears on odata with odata_clk = 1 on the following cycle (latency 1); odata holds its value otherwise.
REQ-019 After each transfer, gap counter loads GAP and decrements to 0 each cycle; s_ready low while nonzero.
REQ-020 HEADER: accept exactly 16 bytes; bytes 0..3 must equal 4E 45 53 1A, else ERROR immediately after the mismatching byte is accepted.
REQ-021 Header byte 4 = PRG units (16384 B), byte 5 = CHR units (8192 B), byte 6 bit2 = trainer (512 B).
REQ-022 Body length = PRG*16384 + CHR*8192 + trainer*512, 22-bit unsigned, computed at end of HEADER; PRG == 0 -> ERROR.
REQ-023 BODY: accept exactly the body length, then DONE; header bytes are forwarded on odata like body bytes.
REQ-024 Timeout counter resets on every transfer; reaching TIMEOUT in HEADER or BODY -> ERROR.
REQ-025 DONE/ERROR: grant held, s_ready low; return to IDLE when req bit of the granted source deasserts.
REQ-026 Request deassert during HEADER/BODY -> ERROR on the next cycle; no further bytes accepted.
REQ-027 Non-granted source's s_ready is always 0; its valid/data are ignored.

Reset
REQ-028 Reset: state IDLE, grant 00, odata 00, odata_clk 0, s_ready 0, done 0, error 0, loader_reset 1, all counters 0.
REQ-029 Reset mid-load takes effect in the same cycle, overriding any transfer; the partially sent byte stream is abandoned.

Structure
REQ-030 Shared package holds the state enum, the iNES magic constant, and unit sizes 16384/8192/512.
REQ-031 One sub-module, ines_header_parse: consumes header bytes with index, outputs magic_ok, body_len, prg_zero.

Verification
REQ-032 req=01, header 4E 45 53 1A 01 01 00.., 24576 body bytes, always valid -> 24592 odata_clk pulses, done=1, GAP=1 spacing exact.
REQ-033 req=11 simultaneously -> grant=10; s_ready0 stays 0 throughout load.
REQ-034 Header byte 2 = 54 -> error=1 after 3rd byte accepted; exactly 3 odata_clk pulses.
REQ-035 Valid stalls TIMEOUT=100 cycles mid-BODY -> error=1; released req -> IDLE, loader_reset=1.
REQ-036 Trainer bit set, PRG=1, CHR=0 -> 16384+512 body bytes accepted before done.
REQ-037 Reset asserted mid-BODY -> next cycle all outputs at reset values; new req restarts from HEADER.
